// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - request/response sequencer in front of the GCD engine
module gcd_requester #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    output logic                  gcd_enable_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    input  logic                  gcd_done_i,
    input  logic [DATA_WIDTH-1:0] gcd_result_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [TAG_WIDTH-1:0]  resp_tag_o,
    output logic                  resp_err_o
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state;
    logic [TAG_WIDTH-1:0] tag_cnt;
    logic [TIMER_W-1:0]   timer;

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b0;
            gcd_enable_o <= 1'b0;
            operand_a_o  <= '0;
            operand_b_o  <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_tag_o   <= '0;
            resp_err_o   <= 1'b0;
            tag_cnt      <= '0;
            timer        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready_o) begin
                        req_ready_o <= 1'b1;
                    end else if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        resp_tag_o  <= tag_cnt;
                        tag_cnt     <= tag_cnt + TAG_WIDTH'(1);
                        // gcd(0,x)=x and gcd(0,0)=0 both reduce to a|b when one side is zero
                        if (req_a_i == '0 || req_b_i == '0) begin
                            resp_data_o  <= req_a_i | req_b_i;
                            resp_err_o   <= 1'b0;
                            resp_valid_o <= 1'b1;
                            state        <= RESP;
                        end else begin
                            operand_a_o  <= req_a_i;
                            operand_b_o  <= req_b_i;
                            gcd_enable_o <= 1'b1;
                            timer        <= '0;
                            state        <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    timer <= timer + TIMER_W'(1);
                    // Done is checked first so a result on the last allowed cycle is kept
                    if (gcd_done_i) begin
                        resp_data_o  <= gcd_result_i;
                        resp_err_o   <= 1'b0;
                        gcd_enable_o <= 1'b0;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        resp_data_o  <= '0;
                        resp_err_o   <= 1'b1;
                        gcd_enable_o <= 1'b0;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b0;
                    gcd_enable_o <= 1'b0;
                    resp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - directed self-checking bench for gcd_requester
module tb_gcd_requester;

    localparam int DW = 8;
    localparam int TO = 16;
    localparam int TW = 2;

    logic          clk_i = 1'b0;
    logic          nreset_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] req_a_i = '0;
    logic [DW-1:0] req_b_i = '0;
    logic          gcd_enable_o;
    logic [DW-1:0] operand_a_o;
    logic [DW-1:0] operand_b_o;
    logic          gcd_done_i = 1'b0;
    logic [DW-1:0] gcd_result_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [DW-1:0] resp_data_o;
    logic [TW-1:0] resp_tag_o;
    logic          resp_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_requester #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TAG_WIDTH(TW)) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .gcd_enable_o (gcd_enable_o),
        .operand_a_o  (operand_a_o),
        .operand_b_o  (operand_b_o),
        .gcd_done_i   (gcd_done_i),
        .gcd_result_i (gcd_result_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_tag_o   (resp_tag_o),
        .resp_err_o   (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Presents a request and returns at the negedge of the first cycle after acceptance
    task automatic send_req(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        req_valid_i = 1'b1;
        req_a_i     = a;
        req_b_i     = b;
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL send_req_ready a=%0d b=%0d got %b exp 1", a, b, req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        nreset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({req_ready_o, gcd_enable_o, operand_a_o, operand_b_o, resp_valid_o,
             resp_data_o, resp_tag_o, resp_err_o} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_values got rdy=%b en=%b a=%0d b=%0d v=%b d=%0d t=%0d e=%b exp all 0",
                     req_ready_o, gcd_enable_o, operand_a_o, operand_b_o, resp_valid_o,
                     resp_data_o, resp_tag_o, resp_err_o);
        end
        nreset_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b exp 1", req_ready_o);
        end
    endtask

    task automatic test_basic();
        resp_ready_i = 1'b1;
        send_req(8'd12, 8'd18);
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if ({gcd_enable_o, operand_a_o, operand_b_o, req_ready_o, resp_valid_o} !==
                {1'b1, 8'd12, 8'd18, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_busy k=%0d got en=%b a=%0d b=%0d rdy=%b v=%b exp 1/12/18/0/0",
                         k, gcd_enable_o, operand_a_o, operand_b_o, req_ready_o, resp_valid_o);
            end
            if (k == 5) begin
                gcd_done_i   = 1'b1;
                gcd_result_i = 8'd6;
            end
            @(negedge clk_i);
        end
        gcd_done_i = 1'b0;
        n_checks++;
        if ({resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, gcd_enable_o} !==
            {1'b1, 8'd6, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_resp got v=%b d=%0d t=%0d e=%b en=%b exp 1/6/0/0/0",
                     resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, gcd_enable_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({resp_valid_o, req_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_return_idle got v=%b rdy=%b exp 0/1", resp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_zero_shortcut();
        logic [DW-1:0] va [2];
        logic [DW-1:0] vb [2];
        logic [DW-1:0] vd [2];
        logic [TW-1:0] vt [2];
        va = '{8'd0, 8'd0};
        vb = '{8'd7, 8'd0};
        vd = '{8'd7, 8'd0};
        vt = '{2'd1, 2'd2};
        resp_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_req(va[i], vb[i]);
            n_checks++;
            if ({resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, gcd_enable_o} !==
                {1'b1, vd[i], vt[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL zero_resp i=%0d got v=%b d=%0d t=%0d e=%b en=%b exp 1/%0d/%0d/0/0",
                         i, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, gcd_enable_o,
                         vd[i], vt[i]);
            end
            @(negedge clk_i);
            n_checks++;
            if ({resp_valid_o, req_ready_o, gcd_enable_o} !== 3'b010) begin
                n_fail++;
                $display("FAIL zero_idle i=%0d got v=%b rdy=%b en=%b exp 0/1/0",
                         i, resp_valid_o, req_ready_o, gcd_enable_o);
            end
        end
    endtask

    task automatic test_timeout();
        resp_ready_i = 1'b0;
        send_req(8'd9, 8'd6);
        for (int k = 1; k <= TO; k++) begin
            n_checks++;
            if ({gcd_enable_o, resp_valid_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL timeout_busy k=%0d got en=%b v=%b exp 1/0", k, gcd_enable_o, resp_valid_o);
            end
            @(negedge clk_i);
        end
        n_checks++;
        if ({gcd_enable_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o} !==
            {1'b0, 1'b1, 8'd0, 2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_resp got en=%b v=%b d=%0d t=%0d e=%b exp 0/1/0/3/1",
                     gcd_enable_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o);
        end
        gcd_done_i   = 1'b1;
        gcd_result_i = 8'd55;
        @(negedge clk_i);
        gcd_done_i = 1'b0;
        n_checks++;
        if ({gcd_enable_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o} !==
            {1'b0, 1'b1, 8'd0, 2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL stray_done_resp got en=%b v=%b d=%0d t=%0d e=%b exp 0/1/0/3/1",
                     gcd_enable_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o);
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        gcd_done_i   = 1'b1;
        @(negedge clk_i);
        gcd_done_i = 1'b0;
        n_checks++;
        if ({req_ready_o, gcd_enable_o, resp_valid_o, resp_data_o, resp_err_o} !==
            {1'b1, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL stray_done_idle got rdy=%b en=%b v=%b d=%0d e=%b exp 1/0/0/0/1",
                     req_ready_o, gcd_enable_o, resp_valid_o, resp_data_o, resp_err_o);
        end
    endtask

    task automatic test_done_at_timeout();
        resp_ready_i = 1'b1;
        send_req(8'd15, 8'd12);
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) begin
                gcd_done_i   = 1'b1;
                gcd_result_i = 8'd3;
            end
            @(negedge clk_i);
        end
        gcd_done_i = 1'b0;
        n_checks++;
        if ({resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, gcd_enable_o} !==
            {1'b1, 8'd3, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL boundary_resp got v=%b d=%0d t=%0d e=%b en=%b exp 1/3/0/0/0",
                     resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, gcd_enable_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] va [5];
        logic [DW-1:0] vb [5];
        logic [DW-1:0] vd [5];
        logic [TW-1:0] vt [5];
        va = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd11};
        vb = '{8'd3, 8'd0, 8'd9, 8'd0, 8'd0};
        vd = '{8'd3, 8'd5, 8'd9, 8'd0, 8'd11};
        vt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        nreset_i = 1'b0;
        @(negedge clk_i);
        nreset_i     = 1'b1;
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_a_i      = va[0];
        req_b_i      = vb[0];
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            while (!req_ready_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            @(negedge clk_i);
            if (i < 4) begin
                req_a_i = va[i+1];
                req_b_i = vb[i+1];
            end else begin
                req_valid_i = 1'b0;
            end
            for (int s = 0; s < 5; s++) begin
                if (s == 4) resp_ready_i = 1'b1;
                n_checks++;
                if ({resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, req_ready_o} !==
                    {1'b1, vd[i], vt[i], 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_stall i=%0d s=%0d got v=%b d=%0d t=%0d e=%b rdy=%b exp 1/%0d/%0d/0/0",
                             i, s, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o, req_ready_o,
                             vd[i], vt[i]);
                end
                @(negedge clk_i);
            end
            resp_ready_i = 1'b0;
        end
        n_checks++;
        if ({resp_valid_o, req_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_end got v=%b rdy=%b exp 0/1", resp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        resp_ready_i = 1'b1;
        send_req(8'd8, 8'd4);
        repeat (2) @(negedge clk_i);
        nreset_i = 1'b0;
        @(negedge clk_i);
        nreset_i = 1'b1;
        n_checks++;
        if ({req_ready_o, gcd_enable_o, operand_a_o, operand_b_o, resp_valid_o,
             resp_data_o, resp_tag_o, resp_err_o} !== 30'd0) begin
            n_fail++;
            $display("FAIL midreset_values got rdy=%b en=%b a=%0d b=%0d v=%b d=%0d t=%0d e=%b exp all 0",
                     req_ready_o, gcd_enable_o, operand_a_o, operand_b_o, resp_valid_o,
                     resp_data_o, resp_tag_o, resp_err_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({req_ready_o, resp_valid_o, gcd_enable_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_no_resp got rdy=%b v=%b en=%b exp 1/0/0",
                     req_ready_o, resp_valid_o, gcd_enable_o);
        end
        send_req(8'd21, 8'd14);
        n_checks++;
        if ({gcd_enable_o, operand_a_o, operand_b_o} !== {1'b1, 8'd21, 8'd14}) begin
            n_fail++;
            $display("FAIL midreset_busy got en=%b a=%0d b=%0d exp 1/21/14",
                     gcd_enable_o, operand_a_o, operand_b_o);
        end
        @(negedge clk_i);
        gcd_done_i   = 1'b1;
        gcd_result_i = 8'd7;
        @(negedge clk_i);
        gcd_done_i = 1'b0;
        n_checks++;
        if ({resp_valid_o, resp_data_o, resp_tag_o, resp_err_o} !== {1'b1, 8'd7, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_resp got v=%b d=%0d t=%0d e=%b exp 1/7/0/0",
                     resp_valid_o, resp_data_o, resp_tag_o, resp_err_o);
        end
        @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_zero_shortcut();
        test_timeout();
        test_done_at_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
